// File: rtl/gray_counter_pkg.sv
// Shared Gray-code constants and helpers for the counter and the downstream conversion stage.
package gray_pkg;

  localparam int GRAY_MIN_W = 2;
  localparam int GRAY_MAX_W = 16;

  // Sized to the widest legal counter; narrower callers zero-extend and slice the result.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray counter; master drives controls, slave is the counter.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic             tc;
  logic             wrap;

  modport master (output en, up, load, load_gray, input g, b, tc, wrap);
  modport slave  (input en, up, load, load_gray, output g, b, tc, wrap);
endinterface

// File: rtl/gray_counter_gray_to_binary.sv
// Combinational Gray-to-binary decoder; each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  // Prefix-XOR form avoids a bit-to-bit combinational chain on the output vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_o[i] = ^g_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered Gray and binary outputs, synchronous Gray load and wrap pulse.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_counter_if.slave   bus
);

  if (WIDTH < GRAY_MIN_W || WIDTH > GRAY_MAX_W) begin : g_width_chk
    $error("gray_counter: WIDTH=%0d outside legal range %0d..%0d", WIDTH, GRAY_MIN_W, GRAY_MAX_W);
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  gray_to_binary #(.WIDTH(WIDTH)) u_load_dec (
    .g_i (bus.load_gray),
    .b_o (load_bin)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        cnt_d  = cnt_q + 1'b1;
        wrap_d = &cnt_q;
      end else begin
        cnt_d  = cnt_q - 1'b1;
        wrap_d = ~|cnt_q;
      end
    end
  end

  // Gray is derived from the next binary value so both registers load on the same edge.
  assign g_d = WIDTH'(bin2gray(GRAY_MAX_W'(cnt_d)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.g    = g_q;
  assign bus.b    = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.up ? (&cnt_q) : (~|cnt_q);

endmodule
